// File: rtl/modn_sequencer_pkg.sv
// Shared definitions for the modulo-N sequencer: step-mode encoding and small helpers.
// Imported by the sequencer top and reusable by other FSM blocks.
package modn_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_MIRROR = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // True for the two modes that can wrap around the ends of the state range.
  function automatic logic mode_can_wrap(input mode_e m);
    return (m == MODE_UP) || (m == MODE_DOWN);
  endfunction

endpackage

// File: rtl/modn_sequencer_sat_counter.sv
// Saturating up-counter used for the wrap-event count.
// Synchronous clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int WC = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [WC-1:0] q
);

  logic [WC-1:0] r_q;
  logic          w_full;

  assign w_full = (r_q == {WC{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && !w_full) begin
      r_q <= r_q + WC'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/modn_sequencer.sv
// Modulo-N state sequencer: steps up, down, mirror (s -> N-1-s) or holds,
// flags the terminal state and counts wrap events in a saturating counter.
module modn_sequencer
  import modn_sequencer_pkg::*;
#(
  parameter  int N  = 10,
  parameter  int WC = 8,
  localparam int W  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          clr,
  output logic [W-1:0]  ps,
  output logic [W-1:0]  ns,
  output logic          tc,
  output logic          wrap,
  output logic [WC-1:0] wrap_cnt,
  output logic          err
);

  localparam logic [W:0]   N_EXT = (W+1)'(N);
  localparam logic [W-1:0] LAST  = W'(N - 1);

  logic [W-1:0] r_ps;
  logic         r_wrap;
  logic         r_err;

  logic [W-1:0] w_ns;
  logic [W:0]   w_mirror_ext;
  logic         w_ps_legal;
  logic         w_load_legal;
  logic         w_wrap_step;
  logic         w_err_set;
  mode_e        w_mode;

  assign w_mode       = mode_e'(mode);
  assign w_ps_legal   = ({1'b0, r_ps} < N_EXT);
  assign w_load_legal = ({1'b0, load_val} < N_EXT);
  // Extra bit keeps N-1-ps from underflowing before truncation.
  assign w_mirror_ext = N_EXT - (W+1)'(1) - {1'b0, r_ps};

  // Load wins over stepping; an upset state recovers to 0 whether or not en is set.
  always_comb begin
    w_ns        = r_ps;
    w_wrap_step = 1'b0;
    w_err_set   = 1'b0;
    if (load) begin
      if (w_load_legal) begin
        w_ns = load_val;
      end else begin
        w_err_set = 1'b1;
      end
    end else if (!w_ps_legal) begin
      w_ns = '0;
    end else if (en) begin
      case (w_mode)
        MODE_UP: begin
          if (r_ps == LAST) begin
            w_ns        = '0;
            w_wrap_step = 1'b1;
          end else begin
            w_ns = r_ps + W'(1);
          end
        end
        MODE_DOWN: begin
          if (r_ps == '0) begin
            w_ns        = LAST;
            w_wrap_step = 1'b1;
          end else begin
            w_ns = r_ps - W'(1);
          end
        end
        MODE_MIRROR: w_ns = w_mirror_ext[W-1:0];
        MODE_HOLD:   w_ns = r_ps;
        default:     w_ns = r_ps;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ps   <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_ps   <= w_ns;
      r_wrap <= w_wrap_step;
      // Setting err beats a same-cycle clear.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (clr) begin
        r_err <= 1'b0;
      end
    end
  end

  sat_counter #(
    .WC(WC)
  ) u_wrap_cnt (
    .clk(clk),
    .rst(rst),
    .inc(w_wrap_step),
    .clr(clr),
    .q  (wrap_cnt)
  );

  assign ps   = r_ps;
  assign ns   = w_ns;
  assign tc   = (r_ps == LAST);
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule
